// File: rtl/trace_drain.sv
// Buffers completed trace records, tags each with {seq, drop_cnt} and streams them out as header + payload beats.
// Optional TRACE_DRAIN_TIMESTAMP_EN adds a stored counter_i beat between header and payload.
module trace_drain #(
    parameter int RECORD_WIDTH = 128,
    parameter int OUT_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trace_valid_i,
    input  logic [RECORD_WIDTH-1:0]       trace_data_i,
    input  logic                          capture_enable_i,
    input  logic                          lock_i,
    input  logic [31:0]                   counter_i,
    input  logic                          out_ready_i,
    output logic                          out_valid_o,
    output logic [OUT_WIDTH-1:0]          out_data_o,
    output logic                          out_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          idle_o
);
    localparam int N  = RECORD_WIDTH / OUT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
`ifdef TRACE_DRAIN_TIMESTAMP_EN
        S_TS   = 2'd2,
`endif
        S_PAY  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [7:0]          seq_q, seq_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;

    logic [23:0]             meta_mem [FIFO_DEPTH];
    logic [RECORD_WIDTH-1:0] pay_mem  [FIFO_DEPTH];
`ifdef TRACE_DRAIN_TIMESTAMP_EN
    logic [31:0]             ts_mem   [FIFO_DEPTH];
`else
    logic                    unused_counter;
    assign unused_counter = ^counter_i;
`endif

    logic full, empty, beat_last, offer, push, pop, drop;
    logic [RECORD_WIDTH-1:0] head_pay;

    always_comb begin
        full      = (level_q == LW'(FIFO_DEPTH));
        empty     = (level_q == '0);
        beat_last = (beat_q == BW'(N - 1));
        // Only the final payload handshake frees the slot; earlier beats keep the head stable.
        pop       = (state_q == S_PAY) && beat_last && out_ready_i;
        offer     = trace_valid_i && capture_enable_i && !lock_i;
        push      = offer && (!full || pop);
        drop      = offer && full && !pop;

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d   = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        if (pop && !push) level_d = level_q - LW'(1);

        seq_d      = push ? seq_q + 8'd1 : seq_q;
        drop_cnt_d = drop_cnt_q;
        if (push)
            drop_cnt_d = 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
        overflow_d = overflow_q || drop;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: if (!empty) begin
                state_d = S_HDR;
                beat_d  = '0;
            end
            S_HDR: if (out_ready_i) begin
`ifdef TRACE_DRAIN_TIMESTAMP_EN
                state_d = S_TS;
`else
                state_d = S_PAY;
`endif
                beat_d  = '0;
            end
`ifdef TRACE_DRAIN_TIMESTAMP_EN
            S_TS: if (out_ready_i) state_d = S_PAY;
`endif
            S_PAY: if (out_ready_i) begin
                if (beat_last) begin
                    state_d = (level_d != '0) ? S_HDR : S_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d  = beat_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_pay    = pay_mem[rd_ptr_q];
        out_data_o  = '0;
        out_valid_o = (state_q != S_IDLE);
        out_last_o  = (state_q == S_PAY) && beat_last;
        case (state_q)
            S_HDR: out_data_o[31:0] = {8'hA5, meta_mem[rd_ptr_q]};
`ifdef TRACE_DRAIN_TIMESTAMP_EN
            S_TS:  out_data_o[31:0] = ts_mem[rd_ptr_q];
`endif
            S_PAY: begin
                // Most-significant slice goes out first.
                for (int i = 0; i < N; i++) begin
                    if (beat_q == BW'(i))
                        out_data_o = head_pay[RECORD_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
                end
            end
            default: out_data_o = '0;
        endcase
    end

    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign idle_o       = empty && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            meta_mem[wr_ptr_q] <= {seq_q, drop_cnt_q};
            pay_mem[wr_ptr_q]  <= trace_data_i;
`ifdef TRACE_DRAIN_TIMESTAMP_EN
            ts_mem[wr_ptr_q]   <= counter_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= 8'd0;
            drop_cnt_q <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end
endmodule
